// File: rtl/control_unit_top_20.sv
// rtl/control_unit_top_20.sv - registered instruction decoder; define CU_SHIFT_EN to decode tipo=11 shifts
module control_unit_top_20 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] tipo,
    input  logic [1:0] op,
    input  logic       Inm,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       ResultSrc,
    output logic       Branch,
    output logic [2:0] ALUControl
);

    localparam logic [1:0] CLASS_ARITH = 2'b00;
    localparam logic [1:0] CLASS_MEM   = 2'b01;
    localparam logic [1:0] CLASS_CTRL  = 2'b10;
    localparam logic [1:0] CLASS_SHIFT = 2'b11;

    localparam logic [1:0] IMM_ARITH  = 2'b00;
    localparam logic [1:0] IMM_MEM    = 2'b01;
    localparam logic [1:0] IMM_BRANCH = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
`ifdef CU_SHIFT_EN
    localparam logic [2:0] ALU_LSL = 3'b100;
    localparam logic [2:0] ALU_LSR = 3'b101;
`endif

    logic       reg_write_d;
    logic [1:0] imm_src_d;
    logic       alu_src_d;
    logic       mem_write_d;
    logic       result_src_d;
    logic       branch_d;
    logic [2:0] alu_control_d;

    // Every path starts from the NOP word so unlisted encodings stay inert.
    always_comb begin
        reg_write_d   = 1'b0;
        imm_src_d     = IMM_ARITH;
        alu_src_d     = 1'b0;
        mem_write_d   = 1'b0;
        result_src_d  = 1'b0;
        branch_d      = 1'b0;
        alu_control_d = ALU_ADD;
        case (tipo)
            CLASS_ARITH: begin
                reg_write_d = 1'b1;
                alu_src_d   = Inm;
                case (op)
                    2'b00:   alu_control_d = ALU_ADD;
                    2'b01:   alu_control_d = ALU_SUB;
                    2'b10:   alu_control_d = ALU_AND;
                    default: alu_control_d = ALU_OR;
                endcase
            end
            CLASS_MEM: begin
                if (op == 2'b01) begin
                    reg_write_d  = 1'b1;
                    imm_src_d    = IMM_MEM;
                    alu_src_d    = 1'b1;
                    result_src_d = 1'b1;
                end else if (op == 2'b10) begin
                    mem_write_d = 1'b1;
                    imm_src_d   = IMM_MEM;
                    alu_src_d   = 1'b1;
                end
            end
            CLASS_CTRL: begin
                if (op == 2'b00) begin
                    branch_d  = 1'b1;
                    imm_src_d = IMM_BRANCH;
                    alu_src_d = 1'b1;
                end else if (op == 2'b10) begin
                    // Compare only drives the ALU for its flags; nothing is written back.
                    alu_src_d     = Inm;
                    alu_control_d = ALU_SUB;
                end
            end
            CLASS_SHIFT: begin
`ifdef CU_SHIFT_EN
                if (op == 2'b00 || op == 2'b01) begin
                    reg_write_d   = 1'b1;
                    alu_src_d     = Inm;
                    alu_control_d = (op == 2'b00) ? ALU_LSL : ALU_LSR;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite   <= 1'b0;
            ImmSrc     <= 2'b00;
            ALUSrc     <= 1'b0;
            MemWrite   <= 1'b0;
            ResultSrc  <= 1'b0;
            Branch     <= 1'b0;
            ALUControl <= 3'b000;
        end else begin
            RegWrite   <= reg_write_d;
            ImmSrc     <= imm_src_d;
            ALUSrc     <= alu_src_d;
            MemWrite   <= mem_write_d;
            ResultSrc  <= result_src_d;
            Branch     <= branch_d;
            ALUControl <= alu_control_d;
        end
    end

endmodule

// File: tb/tb_control_unit_top_20.sv
// tb/tb_control_unit_top_20.sv - directed-vector bench for control_unit_top_20
module tb_control_unit_top_20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] tipo;
    logic [1:0] op;
    logic       Inm;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic       ResultSrc;
    logic       Branch;
    logic [2:0] ALUControl;

    int vectors = 0;
    int miscompares = 0;

    // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl}
    logic [9:0] word;
    assign word = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl};

    localparam logic [9:0] NOP = 10'b0;

    always #5 clk = ~clk;

    control_unit_top_20 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tipo       (tipo),
        .op         (op),
        .Inm        (Inm),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .MemWrite   (MemWrite),
        .ResultSrc  (ResultSrc),
        .Branch     (Branch),
        .ALUControl (ALUControl)
    );

    task automatic drive(input logic [1:0] t, input logic [1:0] o, input logic i);
        @(negedge clk);
        tipo = t;
        op   = o;
        Inm  = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [9:0] exp;
        rst_n = 1'b0;
        tipo = 2'b00; op = 2'b00; Inm = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (word !== NOP) begin
            miscompares++;
            $display("FAIL reset_edge1 got %b want %b", word, NOP);
        end
        @(posedge clk); #1;
        vectors++;
        if (word !== NOP) begin
            miscompares++;
            $display("FAIL reset_edge2 got %b want %b", word, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL reset_release_add got %b want %b", word, exp);
        end
    endtask

    task automatic test_arith;
        logic [9:0] exp;
        drive(2'b00, 2'b01, 1'b1);
        exp = {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL sub_imm got %b want %b", word, exp);
        end
        drive(2'b00, 2'b10, 1'b0);
        exp = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL and_reg got %b want %b", word, exp);
        end
        drive(2'b00, 2'b11, 1'b1);
        exp = {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL or_imm got %b want %b", word, exp);
        end
    endtask

    task automatic test_back_to_back_mem;
        logic [9:0] exp;
        drive(2'b01, 2'b01, 1'b0);
        exp = {1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL ldr got %b want %b", word, exp);
        end
        drive(2'b01, 2'b10, 1'b1);
        exp = {1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL str got %b want %b", word, exp);
        end
    endtask

    task automatic test_branch_cmp;
        logic [9:0] exp;
        drive(2'b10, 2'b00, 1'b0);
        exp = {1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL branch got %b want %b", word, exp);
        end
        drive(2'b10, 2'b10, 1'b0);
        exp = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL cmp_reg got %b want %b", word, exp);
        end
        drive(2'b10, 2'b10, 1'b1);
        exp = {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL cmp_imm got %b want %b", word, exp);
        end
    endtask

    task automatic test_reserved;
        logic [9:0] exp;
        logic [4:0] codes [6] = '{5'b01_00_1, 5'b01_11_0, 5'b10_01_1, 5'b10_11_0, 5'b11_10_1, 5'b11_11_0};
        foreach (codes[k]) begin
            drive(codes[k][4:3], codes[k][2:1], codes[k][0]);
            vectors++;
            if (word !== NOP) begin
                miscompares++;
                $display("FAIL reserved_%b got %b want %b", codes[k], word, NOP);
            end
        end
        drive(2'b11, 2'b00, 1'b1);
`ifdef CU_SHIFT_EN
        exp = {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100};
`else
        exp = NOP;
`endif
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL shift_lsl got %b want %b", word, exp);
        end
        drive(2'b11, 2'b01, 1'b0);
`ifdef CU_SHIFT_EN
        exp = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101};
`else
        exp = NOP;
`endif
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL shift_lsr got %b want %b", word, exp);
        end
    endtask

    task automatic test_latching;
        logic [9:0] exp;
        drive(2'b01, 2'b01, 1'b0);
        exp = {1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        #2;
        tipo = 2'b10; op = 2'b00; Inm = 1'b1;
        #1;
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL midcycle_hold got %b want %b", word, exp);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL async_reset_ignored got %b want %b", word, exp);
        end
        @(posedge clk); #1;
        vectors++;
        if (word !== NOP) begin
            miscompares++;
            $display("FAIL midstream_reset got %b want %b", word, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = {1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
        vectors++;
        if (word !== exp) begin
            miscompares++;
            $display("FAIL post_reset_branch got %b want %b", word, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tipo = 2'b00; op = 2'b00; Inm = 1'b0;
        test_reset;
        test_arith;
        test_back_to_back_mem;
        test_branch_cmp;
        test_reserved;
        test_latching;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
